random_multi: RTL and testbench

Parametrised successor to the single-position random generator for the hole-selection game logic. On request it draws `N_CH` mutually distinct positions in the range 1..`N_POS` from a free-running 16-bit Galois LFSR. It returns them together with a hole bitmask, under a req/busy/valid handshake, with a bounded retry count and a deterministic fallback. It sits between the game-control FSM, which issues `req` once per round, and the display/scoring logic, which consumes `positions`/`mask`.

---
 rtl/random_pkg.sv | 26 ++
 rtl/lfsr_galois.sv | 32 +++
 rtl/random_multi.sv | 185 ++++++++++++++++++
 tb/tb_random_multi.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/random_pkg.sv
// Shared constants, FSM state type and the lowest-free-position scan for random_multi.
package random_pkg;

    localparam int unsigned LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [LFSR_W-1:0] SEED_DEFAULT = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DONE
    } state_t;

    // Returns the lowest position p in 1..n whose bit p-1 is clear in used, or 0 if none.
    function automatic logic [7:0] lowest_free_pos(input logic [15:0] used, input int n);
        logic [7:0] pos;
        pos = '0;
        for (int i = 15; i >= 0; i--) begin
            if (i < n && !used[i]) begin
                pos = 8'(i + 1);
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Free-running 16-bit right-shifting Galois LFSR with seed load; a zero seed loads SEED_INIT.
module lfsr_galois
    import random_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED_INIT = SEED_DEFAULT
) (
    input  logic              clk_1hz,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_d;

    // Load wins over the shift so a reseed takes effect on the very next cycle.
    always_comb begin
        state_d = (state >> 1) ^ (state[0] ? LFSR_TAPS : '0);
        if (load) begin
            state_d = (seed == '0) ? SEED_INIT : seed;
        end
    end

    always_ff @(posedge clk_1hz) begin
        if (rst) begin
            state <= SEED_INIT;
        end else begin
            state <= state_d;
        end
    end

endmodule

// File: rtl/random_multi.sv
// Draws N_CH distinct hole positions per request with bounded retries and lowest-free fallback.
// Optional RANDOM_NOREPEAT_EN: also excludes every hole delivered by the previous draw.
module random_multi
    import random_pkg::*;
#(
    parameter int unsigned       N_POS     = 9,
    parameter int unsigned       N_CH      = 2,
    parameter int unsigned       POS_W     = 4,
    parameter int unsigned       MAX_TRY   = 8,
    parameter logic [LFSR_W-1:0] SEED_INIT = SEED_DEFAULT
) (
    input  logic                    clk_1hz,
    input  logic                    rst,
    input  logic                    seed_load,
    input  logic [LFSR_W-1:0]       seed_in,
    input  logic                    req,
    output logic                    busy,
    output logic                    valid,
    output logic [N_CH*POS_W-1:0]   positions,
    output logic [N_POS-1:0]        mask
);

    localparam int unsigned OUT_W = N_CH * POS_W;
    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned TRY_W = $clog2(MAX_TRY + 1);
    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(N_CH - 1);
    localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRY);

    function automatic logic [OUT_W-1:0] reset_positions();
        logic [OUT_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            r[i*POS_W +: POS_W] = POS_W'(i + 1);
        end
        return r;
    endfunction

    localparam logic [OUT_W-1:0] POS_RST  = reset_positions();
    localparam logic [N_POS-1:0] MASK_RST = N_POS'((32'd1 << N_CH) - 32'd1);

    state_t             state_q, state_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [TRY_W-1:0]   try_q, try_d;
    logic [N_POS-1:0]   work_mask_q, work_mask_d;
    logic [OUT_W-1:0]   work_pos_q, work_pos_d;
    logic [OUT_W-1:0]   positions_d;
    logic [N_POS-1:0]   mask_d;
    logic               valid_d;
    logic               busy_d;

    logic [LFSR_W-1:0]  lfsr;
    logic               lfsr_hi_unused;
    logic [7:0]         cand_idx;
    logic [POS_W-1:0]   cand;
    logic [N_POS-1:0]   cand_bit;
    logic [N_POS-1:0]   blocked;
    logic [POS_W-1:0]   fb_pos;
    logic [N_POS-1:0]   fb_bit;
    logic [POS_W-1:0]   sel_pos;
    logic [N_POS-1:0]   sel_bit;

    lfsr_galois #(
        .SEED_INIT (SEED_INIT)
    ) u_lfsr (
        .clk_1hz (clk_1hz),
        .rst     (rst),
        .load    (seed_load),
        .seed    (seed_in),
        .state   (lfsr)
    );

    assign lfsr_hi_unused = ^lfsr[LFSR_W-1:8];

`ifdef RANDOM_NOREPEAT_EN
    logic [N_POS-1:0] prev_mask_q, prev_mask_d;

    if (2 * N_CH > N_POS) begin : g_norepeat_chk
        $error("random_multi: no-repeat mode needs 2*N_CH <= N_POS");
    end

    assign blocked = work_mask_q | prev_mask_q;
`else
    assign blocked = work_mask_q;
`endif

    // Candidate from the low LFSR byte plus the fallback pick over currently blocked holes.
    always_comb begin
        cand_idx = lfsr[7:0] % 8'(N_POS);
        cand     = POS_W'(cand_idx + 8'd1);
        cand_bit = N_POS'(1) << cand_idx;
        fb_pos   = POS_W'(lowest_free_pos(16'(blocked), int'(N_POS)));
        fb_bit   = N_POS'(1) << (fb_pos - POS_W'(1));
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        try_d       = try_q;
        work_mask_d = work_mask_q;
        work_pos_d  = work_pos_q;
        positions_d = positions;
        mask_d      = mask;
        valid_d     = 1'b0;
        busy_d      = busy;
        sel_pos     = cand;
        sel_bit     = cand_bit;
`ifdef RANDOM_NOREPEAT_EN
        prev_mask_d = prev_mask_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d     = DRAW;
                    ch_d        = '0;
                    try_d       = '0;
                    work_mask_d = '0;
                    busy_d      = 1'b1;
                end
            end
            DRAW: begin
                if (try_q == TRY_LIMIT) begin
                    sel_pos = fb_pos;
                    sel_bit = fb_bit;
                end
                // Retry budget exhausted forces the fallback even for a free candidate.
                if (try_q != TRY_LIMIT && (cand_bit & blocked) != '0) begin
                    try_d = try_q + TRY_W'(1);
                end else begin
                    work_pos_d[ch_q*POS_W +: POS_W] = sel_pos;
                    work_mask_d = work_mask_q | sel_bit;
                    try_d       = '0;
                    if (ch_q == LAST_CH) begin
                        state_d = DONE;
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                    end
                end
            end
            DONE: begin
                positions_d = work_pos_q;
                mask_d      = work_mask_q;
                valid_d     = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
`ifdef RANDOM_NOREPEAT_EN
                prev_mask_d = work_mask_q;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_1hz) begin
        if (rst) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            try_q       <= '0;
            work_mask_q <= '0;
            work_pos_q  <= '0;
            positions   <= POS_RST;
            mask        <= MASK_RST;
            valid       <= 1'b0;
            busy        <= 1'b0;
`ifdef RANDOM_NOREPEAT_EN
            prev_mask_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            try_q       <= try_d;
            work_mask_q <= work_mask_d;
            work_pos_q  <= work_pos_d;
            positions   <= positions_d;
            mask        <= mask_d;
            valid       <= valid_d;
            busy        <= busy_d;
`ifdef RANDOM_NOREPEAT_EN
            prev_mask_q <= prev_mask_d;
`endif
        end
    end

endmodule

// File: tb/tb_random_multi.sv
// Self-checking bench for random_multi: reset, seed load, randomized draws against a draw-level model.
module tb_random_multi;

    localparam logic [15:0] SEED_INIT = 16'hACE1;

    logic        clk_1hz   = 1'b0;
    logic        rst       = 1'b1;
    logic        seed_load = 1'b0;
    logic [15:0] seed_in   = 16'h0000;
    logic        req_a     = 1'b0;
    logic        req_b     = 1'b0;

    logic        busy_a, valid_a;
    logic [7:0]  pos_a;
    logic [8:0]  mask_a;
    logic        busy_b, valid_b;
    logic [11:0] pos_b;
    logic [2:0]  mask_b;

    logic [15:0] m_a, m_b;
    logic [15:0] prev_a = 16'h0;
    int          n_pass = 0;
    int          n_checks = 0;

    always #5 clk_1hz = ~clk_1hz;

    random_multi #(.N_POS(9), .N_CH(2), .POS_W(4), .MAX_TRY(8), .SEED_INIT(SEED_INIT)) dut_a (
        .clk_1hz (clk_1hz), .rst (rst), .seed_load (seed_load), .seed_in (seed_in),
        .req (req_a), .busy (busy_a), .valid (valid_a), .positions (pos_a), .mask (mask_a)
    );

`ifndef RANDOM_NOREPEAT_EN
    random_multi #(.N_POS(3), .N_CH(3), .POS_W(4), .MAX_TRY(1), .SEED_INIT(SEED_INIT)) dut_b (
        .clk_1hz (clk_1hz), .rst (rst), .seed_load (seed_load), .seed_in (seed_in),
        .req (req_b), .busy (busy_b), .valid (valid_b), .positions (pos_b), .mask (mask_b)
    );
`else
    assign busy_b  = 1'b0;
    assign valid_b = 1'b0;
    assign pos_b   = 12'h0;
    assign mask_b  = 3'h0;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        if (rst) return SEED_INIT;
        if (seed_load) return (seed_in == 16'h0) ? SEED_INIT : seed_in;
        return lfsr_step(v);
    endfunction

    // One clock: advance both reference LFSRs by the inputs seen at the edge, then settle.
    task automatic tick();
        @(posedge clk_1hz);
        m_a = lfsr_next(m_a);
        m_b = lfsr_next(m_b);
        if (rst) prev_a = 16'h0;
        #1;
    endtask

    // Draw-level reference: walks the random sequence one value per decision cycle.
    function automatic void model_draw(input logic [15:0] start, input int npos, input int nch,
                                       input int maxtry, input logic [15:0] prev,
                                       output logic [63:0] posv, output logic [15:0] msk,
                                       output int ncyc);
        logic [15:0] v;
        int tries, c, p;
        bit found;
        v = start; posv = '0; msk = '0; ncyc = 0;
        for (int ch = 0; ch < nch; ch++) begin
            tries = 0;
            p = 0;
            while (p == 0) begin
                c = int'(v[7:0]) % npos + 1;
                if (tries == maxtry) begin
                    found = 0;
                    for (int q = 1; q <= npos; q++)
                        if (!found && !msk[q-1] && !prev[q-1]) begin p = q; found = 1; end
                end else if (msk[c-1] || prev[c-1]) begin
                    tries++;
                end else begin
                    p = c;
                end
                v = lfsr_step(v);
                ncyc++;
            end
            posv[ch*4 +: 4] = 4'(p);
            msk[p-1] = 1'b1;
        end
    endfunction

    function automatic logic get_valid(input int w); return (w == 0) ? valid_a : valid_b; endfunction
    function automatic logic get_busy(input int w);  return (w == 0) ? busy_a : busy_b;   endfunction
    function automatic logic [63:0] get_pos(input int w);
        return (w == 0) ? 64'(pos_a) : 64'(pos_b);
    endfunction
    function automatic logic [63:0] get_mask(input int w);
        return (w == 0) ? 64'(mask_a) : 64'(mask_b);
    endfunction

    task automatic do_draw(input int w, input bit hold);
        logic [63:0] exp_pos;
        logic [15:0] exp_msk;
        logic [3:0]  p0, p1;
        int ncyc, n, npos, nch, maxtry, s;
        npos = (w == 0) ? 9 : 3;
        nch = (w == 0) ? 2 : 3;
        maxtry = (w == 0) ? 8 : 1;
        if (w == 0) req_a = 1'b1; else req_b = 1'b1;
        tick();
        model_draw((w == 0) ? m_a : m_b, npos, nch, maxtry, (w == 0) ? prev_a : 16'h0,
                   exp_pos, exp_msk, ncyc);
        if (!hold) begin req_a = 1'b0; req_b = 1'b0; end
        n = 0;
        while (!get_valid(w) && n < 60) begin
            if (n <= ncyc) check("busy_during_draw", 64'(get_busy(w)), 64'd1);
            tick();
            n++;
        end
        if (!get_valid(w)) begin
            check("valid_timeout", 64'd0, 64'd1);
            req_a = 1'b0; req_b = 1'b0;
            return;
        end
        check("latency", 64'(n), 64'(ncyc + 1));
        check("positions", get_pos(w), exp_pos);
        check("mask", get_mask(w), 64'(exp_msk));
        if (w == 0) begin
            p0 = pos_a[3:0];
            p1 = pos_a[7:4];
            check("lat_window", 64'(n >= 3 && n <= 19), 64'd1);
            check("distinct_in_range", 64'(p0 >= 1 && p0 <= 9 && p1 >= 1 && p1 <= 9 && p0 != p1), 64'd1);
            check("popcount", 64'($countones(mask_a)), 64'd2);
`ifdef RANDOM_NOREPEAT_EN
            check("no_repeat", 64'(16'(mask_a) & prev_a), 64'd0);
            prev_a = 16'(mask_a);
`endif
        end else begin
            s = 0;
            for (int i = 0; i < 3; i++) begin
                p0 = pos_b[i*4 +: 4];
                if (p0 >= 1 && p0 <= 3) s = s | (1 << (p0 - 1));
            end
            check("full_mask", 64'(mask_b), 64'h7);
            check("full_set", 64'(s), 64'h7);
        end
        if (!hold) begin
            tick();
            check("busy_after", 64'(get_busy(w)), 64'd0);
            check("valid_pulse", 64'(get_valid(w)), 64'd0);
        end
    endtask

    initial begin
        bit hold;
        tick();
        tick();
        rst = 1'b0;
        check("rst_pos_a", 64'(pos_a), 64'h21);
        check("rst_mask_a", 64'(mask_a), 64'h003);
        check("rst_valid", 64'(valid_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_lfsr", 64'(dut_a.u_lfsr.state), 64'(SEED_INIT));
`ifndef RANDOM_NOREPEAT_EN
        check("rst_pos_b", 64'(pos_b), 64'h321);
        check("rst_mask_b", 64'(mask_b), 64'h7);
`endif

        seed_load = 1'b1;
        seed_in = 16'h0000;
        tick();
        seed_load = 1'b0;
        check("zero_seed", 64'(dut_a.u_lfsr.state), 64'h ACE1);
        tick();
        check("first_step", 64'(dut_a.u_lfsr.state), 64'(lfsr_step(16'hACE1)));
        check("model_track", 64'(dut_a.u_lfsr.state), 64'(m_a));

        for (int i = 0; i < 1000; i++) begin
            if (i % 100 == 0) begin
                seed_in = 16'($urandom);
                seed_load = 1'b1;
                tick();
                seed_load = 1'b0;
            end
            hold = ($urandom_range(0, 3) == 0) && (i % 100 != 99);
            do_draw(0, hold);
        end
        req_a = 1'b0;

`ifndef RANDOM_NOREPEAT_EN
        for (int i = 0; i < 50; i++) do_draw(1, 1'b0);
`endif

        req_a = 1'b1;
        tick();
        req_a = 1'b0;
        tick();
        check("abort_no_valid1", 64'(valid_a), 64'd0);
        tick();
        check("abort_no_valid2", 64'(valid_a), 64'd0);
        rst = 1'b1;
        tick();
        check("abort_no_valid3", 64'(valid_a), 64'd0);
        tick();
        rst = 1'b0;
        check("abort_valid", 64'(valid_a), 64'd0);
        check("abort_busy", 64'(busy_a), 64'd0);
        check("abort_pos", 64'(pos_a), 64'h21);
        check("abort_mask", 64'(mask_a), 64'h003);
        check("abort_lfsr", 64'(dut_a.u_lfsr.state), 64'(m_a));
        do_draw(0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
